// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl
//
// Two-port round-robin arbiter and access sequencer for a single-port RAM
// with combinational read. Each client issues one read or write per
// req/ack handshake. A transaction takes three cycles:
// IDLE (arbitrate and latch) -> ACCESS (RAM strobe) -> ACK (one-cycle pulse).
// All RAM pins, acks and busy come from flops, so there is no combinational
// path from a request to the RAM.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req0/req1           request from port 0 / port 1
//   wr0/wr1             1 = write, 0 = read (valid while req high)
//   addr0/addr1         access address (valid while req high)
//   wdata0/wdata1       write data (valid while req high)
//   ack0/ack1           one-cycle completion pulse
//   rdata0/rdata1       read data, held until that port's next read completes
//   busy                high whenever the sequencer is not idle
//   ram_cs, ram_wr      RAM chip select / write enable, active-high
//   ram_addr, ram_din   RAM address / write data (hold last latched value)
//   ram_dout            RAM read data (combinational from ram_addr)

module ram_arb_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t state;

    logic              last_gnt;   // port granted most recently
    logic              gnt_id;     // port owning the transaction in flight
    logic              wr_lat;     // latched direction of the transaction
    logic              winner;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // A lone requester wins outright; on a tie the port that did not win
    // last time gets the grant.
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else begin
            winner = req1;
        end
        sel_wr    = winner ? wr1    : wr0;
        sel_addr  = winner ? addr1  : addr0;
        sel_wdata = winner ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            wr_lat   <= 1'b0;
            ram_cs   <= 1'b0;
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        // Operands are captured here so later client changes
                        // cannot disturb the access in flight.
                        gnt_id   <= winner;
                        last_gnt <= winner;
                        wr_lat   <= sel_wr;
                        ram_addr <= sel_addr;
                        ram_din  <= sel_wdata;
                        ram_cs   <= 1'b1;
                        ram_wr   <= sel_wr;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (!wr_lat) begin
                        if (gnt_id) begin
                            rdata1 <= ram_dout;
                        end else begin
                            rdata0 <= ram_dout;
                        end
                    end
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    ack0   <= ~gnt_id;
                    ack1   <= gnt_id;
                    state  <= ACK;
                end

                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    ram_cs <= 1'b0;
                    ram_wr <= 1'b0;
                    ack0   <= 1'b0;
                    ack1   <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Testbench for ram_arb_ctrl: directed transactions against a behavioural
// 1024x8 RAM with combinational read and clocked write.

module tb_ram_arb_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0, req1, wr0, wr1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1, busy, ram_cs, ram_wr;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din, ram_dout;

    logic [DATA_W-1:0] mem [0:1023];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ram_arb_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .wr0      (wr0),
        .wr1      (wr1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .busy     (busy),
        .ram_cs   (ram_cs),
        .ram_wr   (ram_wr),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, write on the rising edge.
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic r, input logic w,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (port == 0) begin
            req0 = r; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; wr1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // Step until the given port acks (bounded); returns the ack cycle.
    task automatic wait_ack(input int port, output int at);
        int n;
        n  = 0;
        at = -1;
        while (n < 12) begin
            step();
            n++;
            check("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    // One complete transaction; req dropped once ack is seen.
    task automatic xfer(input int port, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d);
        int at;
        drive(port, 1'b1, w, a, d);
        wait_ack(port, at);
        drive(port, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int at, last, acks, low_run;
        logic [DATA_W-1:0] exp_b2b [4];
        logic [ADDR_W-1:0] adr_b2b [4];

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        // Preload for back-to-back reads.
        mem[10] = 8'h11; mem[20] = 8'h22; mem[30] = 8'h33; mem[40] = 8'h44;
        adr_b2b = '{10'd10, 10'd20, 10'd30, 10'd40};
        exp_b2b = '{8'h11, 8'h22, 8'h33, 8'h44};

        req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        rst = 1'b1;
        step(); step();
        check("rst_ack0", {31'd0, ack0}, 0);
        check("rst_ack1", {31'd0, ack1}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cs", {31'd0, ram_cs}, 0);
        check("rst_wr", {31'd0, ram_wr}, 0);
        check("rst_addr", {22'd0, ram_addr}, 0);
        check("rst_din", {24'd0, ram_din}, 0);
        check("rst_rdata0", {24'd0, rdata0}, 0);
        check("rst_rdata1", {24'd0, rdata1}, 0);
        rst = 1'b0;
        step();

        // Single write, port 0.
        drive(0, 1'b1, 1'b1, 10'd32, 8'hFF);
        step();
        check("w0_cs", {31'd0, ram_cs}, 1);
        check("w0_wr", {31'd0, ram_wr}, 1);
        check("w0_addr", {22'd0, ram_addr}, 32);
        check("w0_din", {24'd0, ram_din}, 8'hFF);
        check("w0_busy", {31'd0, busy}, 1);
        check("w0_early_ack", {31'd0, ack0}, 0);
        step();
        check("w0_ack0", {31'd0, ack0}, 1);
        check("w0_ack1", {31'd0, ack1}, 0);
        check("w0_cs_off", {31'd0, ram_cs}, 0);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        check("w0_ack_end", {31'd0, ack0}, 0);
        check("w0_idle", {31'd0, busy}, 0);
        check("w0_mem", {24'd0, mem[32]}, 8'hFF);
        check("w0_rdata0", {24'd0, rdata0}, 0);

        // Read-back on port 1.
        xfer(0, 1'b1, 10'd64, 8'hAC);
        xfer(1, 1'b1, 10'd128, 8'h9B);
        xfer(1, 1'b0, 10'd64, 8'h00);
        check("rb_64", {24'd0, rdata1}, 8'hAC);
        step(); step();
        check("rb_hold", {24'd0, rdata1}, 8'hAC);
        xfer(1, 1'b0, 10'd128, 8'h00);
        check("rb_128", {24'd0, rdata1}, 8'h9B);

        // Tie after reset.
        rst = 1'b1; step(); rst = 1'b0; step();
        drive(0, 1'b1, 1'b1, 10'd256, 8'h8F);
        drive(1, 1'b1, 1'b1, 10'd512, 8'h7F);
        step();
        check("tie_first", {22'd0, ram_addr}, 256);
        step();
        check("tie_ack0", {31'd0, ack0}, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        step();
        check("tie_gap", {31'd0, busy}, 0);
        step();
        check("tie_second", {22'd0, ram_addr}, 512);
        step();
        check("tie_ack1", {31'd0, ack1}, 1);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
        check("tie_mem256", {24'd0, mem[256]}, 8'h8F);
        check("tie_mem512", {24'd0, mem[512]}, 8'h7F);

        // Fairness: both ports reading continuously; last grant was port 1.
        drive(0, 1'b1, 1'b0, 10'd64, 8'h00);
        drive(1, 1'b1, 1'b0, 10'd128, 8'h00);
        acks = 0; last = -1; low_run = 0;
        for (int n = 0; n < 40 && acks < 6; n++) begin
            step();
            low_run = busy ? 0 : low_run + 1;
            check("fair_busy_gap", {31'd0, low_run > 1}, 0);
            check("fair_excl", {31'd0, ack0 & ack1}, 0);
            if (ack0 || ack1) begin
                check("fair_port", {31'd0, ack1}, acks % 2);
                if (ack0) check("fair_rd0", {24'd0, rdata0}, 8'hAC);
                if (ack1) check("fair_rd1", {24'd0, rdata1}, 8'h9B);
                if (last >= 0) check("fair_space", cyc - last, 3);
                last = cyc;
                acks++;
            end
        end
        check("fair_count", acks, 6);
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();

        // Back-to-back reads on port 0.
        last = -1;
        drive(0, 1'b1, 1'b0, adr_b2b[0], 8'h00);
        for (int i = 0; i < 4; i++) begin
            wait_ack(0, at);
            check("b2b_rdata", {24'd0, rdata0}, {24'd0, exp_b2b[i]});
            check("b2b_no_ack1", {31'd0, ack1}, 0);
            if (last >= 0) check("b2b_space", at - last, 3);
            last = at;
            if (i < 3) drive(0, 1'b1, 1'b0, adr_b2b[i+1], 8'h00);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        step();

        // Reset during ACCESS of a port-1 read.
        drive(1, 1'b1, 1'b0, 10'd64, 8'h00);
        step();
        check("ra_cs_before", {31'd0, ram_cs}, 1);
        #2 rst = 1'b1;
        #1;
        check("ra_cs", {31'd0, ram_cs}, 0);
        check("ra_busy", {31'd0, busy}, 0);
        check("ra_rdata1", {24'd0, rdata1}, 0);
        drive(1, 1'b0, 1'b0, '0, '0);
        for (int n = 0; n < 3; n++) begin
            step();
            check("ra_no_ack1", {31'd0, ack1}, 0);
        end
        rst = 1'b0;
        for (int n = 0; n < 2; n++) begin
            step();
            check("ra_no_ack1_post", {31'd0, ack1}, 0);
        end
        drive(0, 1'b1, 1'b1, 10'd256, 8'h55);
        drive(1, 1'b1, 1'b1, 10'd512, 8'hAA);
        step();
        check("ra_tie_first", {22'd0, ram_addr}, 256);
        check("ra_tie_din", {24'd0, ram_din}, 8'h55);
        step();
        check("ra_tie_ack0", {31'd0, ack0}, 1);
        drive(0, 1'b0, 1'b0, '0, '0);
        wait_ack(1, at);
        drive(1, 1'b0, 1'b0, '0, '0);
        step();
        check("ra_mem256", {24'd0, mem[256]}, 8'h55);
        check("ra_mem512", {24'd0, mem[512]}, 8'hAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
